// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stream_demux_pkg
//  Description : Shared types and constants for the 2-way stream demux.
//                demux_state_t - packet lock state (IDLE / LOCKED)
//                NUM_OUT       - number of output streams
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;

  localparam int NUM_OUT = 2;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/demux_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : demux_out_stage
//  Description : One-entry valid/data/last register slice for one output of
//                the stream demux. A load always wins over a drain, so a beat
//                arriving while the held beat leaves is captured with valid
//                staying high.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                load              - capture din/din_last this cycle
//                din, din_last     - beat to capture
//                ready             - consumer takes the held beat
//                valid, dout, last - registered output beat
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              din_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
      last_d  = din_last;
    end else if (valid_q && ready) begin
      // Drained: data/last keep their last value, only valid drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;
  assign last  = last_q;

endmodule : demux_out_stage
`default_nettype wire

// File: rtl/stream_demux_2way.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_2way
//  Description : Steers each packet of one valid/ready input stream to one of
//                two output streams. The destination is taken from sel on the
//                first beat of a packet and held until the last beat. Each
//                output has its own one-entry register stage, so a stalled
//                consumer never blocks the other output.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                din, din_valid, din_last    - input beat
//                din_ready                   - input beat accepted this cycle
//                sel                         - destination of a new packet
//                dout_n, dout_n_valid,
//                dout_n_last, dout_n_ready   - output stream n (n = 0, 1)
//                busy                        - packet open or a stage occupied
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_2way
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  input  logic              sel,
  output logic [DATA_W-1:0] dout_0,
  output logic              dout_0_valid,
  output logic              dout_0_last,
  input  logic              dout_0_ready,
  output logic [DATA_W-1:0] dout_1,
  output logic              dout_1_valid,
  output logic              dout_1_last,
  input  logic              dout_1_ready,
  output logic              busy
);

  demux_state_t        state_q, state_d;
  logic                sel_q,   sel_d;
  logic                target;
  logic                accept;

  logic [NUM_OUT-1:0]  stage_valid;
  logic [NUM_OUT-1:0]  stage_last;
  logic [NUM_OUT-1:0]  stage_ready;
  logic [NUM_OUT-1:0]  stage_load;
  logic [DATA_W-1:0]   stage_data [NUM_OUT];

  assign stage_ready = {dout_1_ready, dout_0_ready};

  // A new packet follows sel directly; an open packet follows the latched sel.
  assign target = (state_q == IDLE) ? sel : sel_q;

  // The target stage can take a beat if empty or draining this cycle.
  assign din_ready = ~stage_valid[target] | stage_ready[target];
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (accept) begin
      if (state_q == IDLE) begin
        // Single-beat packets never lock and leave sel_q untouched.
        if (!din_last) begin
          state_d = LOCKED;
          sel_d   = sel;
        end
      end else if (din_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_out
    assign stage_load[n] = accept & (target == 1'(n));

    demux_out_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (stage_load[n]),
      .din      (din),
      .din_last (din_last),
      .ready    (stage_ready[n]),
      .valid    (stage_valid[n]),
      .dout     (stage_data[n]),
      .last     (stage_last[n])
    );
  end

  assign dout_0       = stage_data[0];
  assign dout_0_valid = stage_valid[0];
  assign dout_0_last  = stage_last[0];
  assign dout_1       = stage_data[1];
  assign dout_1_valid = stage_valid[1];
  assign dout_1_last  = stage_last[1];

  assign busy = (state_q == LOCKED) | (|stage_valid);

endmodule : stream_demux_2way
`default_nettype wire

// File: tb/tb_stream_demux_2way.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_demux_2way
//  Description : Self-checking bench for stream_demux_2way: directed vector
//                table, a reset-in-packet sequence, and randomized traffic
//                compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_2way;

  localparam int DATA_W   = 8;
  localparam int N_RANDOM = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_last;
  logic              din_ready;
  logic              sel;
  logic [DATA_W-1:0] dout_0;
  logic              dout_0_valid;
  logic              dout_0_last;
  logic              dout_0_ready;
  logic [DATA_W-1:0] dout_1;
  logic              dout_1_valid;
  logic              dout_1_last;
  logic              dout_1_ready;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_demux_2way #(
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .din_last     (din_last),
    .din_ready    (din_ready),
    .sel          (sel),
    .dout_0       (dout_0),
    .dout_0_valid (dout_0_valid),
    .dout_0_last  (dout_0_last),
    .dout_0_ready (dout_0_ready),
    .dout_1       (dout_1),
    .dout_1_valid (dout_1_valid),
    .dout_1_last  (dout_1_last),
    .dout_1_ready (dout_1_ready),
    .busy         (busy)
  );

  // Inputs plus the outputs expected at the falling edge of that cycle.
  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic       last;
    logic       sel;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_l0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic       e_l1;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic dv, input logic [7:0] d, input logic l,
                       input logic s, input logic r0, input logic r1);
    rst          = r;
    din_valid    = dv;
    din          = d;
    din_last     = l;
    sel          = s;
    dout_0_ready = r0;
    dout_1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic v0, input logic [7:0] d0,
                          input logic l0, input logic v1, input logic [7:0] d1, input logic l1,
                          input logic b);
    chk({tag, ".din_ready"}, 32'(din_ready),    32'(rdy));
    chk({tag, ".v0"},        32'(dout_0_valid), 32'(v0));
    chk({tag, ".d0"},        32'(dout_0),       32'(d0));
    chk({tag, ".l0"},        32'(dout_0_last),  32'(l0));
    chk({tag, ".v1"},        32'(dout_1_valid), 32'(v1));
    chk({tag, ".d1"},        32'(dout_1),       32'(d1));
    chk({tag, ".l1"},        32'(dout_1_last),  32'(l1));
    chk({tag, ".busy"},      32'(busy),         32'(b));
  endtask

  // Behavioural model: contents of each output slot plus the open-packet route.
  logic       m_occ  [2];
  logic [7:0] m_data [2];
  logic       m_last [2];
  logic       m_open;
  logic       m_dest;

  task automatic model_clear();
    for (int n = 0; n < 2; n++) begin
      m_occ[n]  = 1'b0;
      m_data[n] = 8'h00;
      m_last[n] = 1'b0;
    end
    m_open = 1'b0;
    m_dest = 1'b0;
  endtask

  task automatic model_cycle(input int idx);
    logic       dest;
    logic       rdy [2];
    logic       room;
    logic       take;
    string      tag;
    rdy[0] = dout_0_ready;
    rdy[1] = dout_1_ready;
    dest   = m_open ? m_dest : sel;
    room   = !m_occ[dest] || rdy[dest];
    @(negedge clk);
    tag = $sformatf("rnd%0d", idx);
    chk_outs(tag, room, m_occ[0], m_data[0], m_last[0], m_occ[1], m_data[1], m_last[1],
             m_open || m_occ[0] || m_occ[1]);
    take = din_valid && room;
    if (rst) begin
      model_clear();
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (take && dest == 1'(n)) begin
          m_occ[n]  = 1'b1;
          m_data[n] = din;
          m_last[n] = din_last;
        end else if (m_occ[n] && rdy[n]) begin
          m_occ[n] = 1'b0;
        end
      end
      if (take) begin
        if (!m_open && !din_last) begin
          m_open = 1'b1;
          m_dest = sel;
        end else if (m_open && din_last) begin
          m_open = 1'b0;
        end
      end
    end
    tick();
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();

    //              rst dv  din    lst sel r0 r1 | rdy v0 d0    l0 v1 d1    l1 busy
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 1, 8'hA1, 0, 0, 1, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 1, 8'hA2, 0, 1, 1, 1,   1, 1, 8'hA1, 0, 0, 8'h00, 0, 1});
    vecs.push_back('{0, 1, 8'hA3, 1, 1, 1, 1,   1, 1, 8'hA2, 0, 0, 8'h00, 0, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 1,   1, 1, 8'hA3, 1, 0, 8'h00, 0, 1});
    vecs.push_back('{0, 1, 8'h11, 1, 1, 1, 1,   1, 0, 8'hA3, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 1, 8'h22, 1, 0, 1, 1,   1, 0, 8'hA3, 1, 1, 8'h11, 1, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 1,   1, 1, 8'h22, 1, 0, 8'h11, 1, 1});
    vecs.push_back('{0, 1, 8'h31, 0, 1, 1, 0,   1, 0, 8'h22, 1, 0, 8'h11, 1, 0});
    vecs.push_back('{0, 1, 8'h32, 1, 0, 1, 0,   0, 0, 8'h22, 1, 1, 8'h31, 0, 1});
    vecs.push_back('{0, 1, 8'h32, 1, 0, 1, 0,   0, 0, 8'h22, 1, 1, 8'h31, 0, 1});
    vecs.push_back('{0, 1, 8'h32, 1, 0, 1, 1,   1, 0, 8'h22, 1, 1, 8'h31, 0, 1});
    vecs.push_back('{0, 1, 8'h40, 1, 0, 1, 0,   1, 0, 8'h22, 1, 1, 8'h32, 1, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 0,   1, 1, 8'h40, 1, 1, 8'h32, 1, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h40, 1, 1, 8'h32, 1, 1});
    vecs.push_back('{0, 1, 8'h51, 0, 0, 0, 1,   1, 0, 8'h40, 1, 0, 8'h32, 1, 0});
    vecs.push_back('{0, 1, 8'h52, 1, 1, 1, 1,   1, 1, 8'h51, 0, 0, 8'h32, 1, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 1,   0, 1, 8'h52, 1, 0, 8'h32, 1, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 1,   1, 1, 8'h52, 1, 0, 8'h32, 1, 1});
    vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h52, 1, 0, 8'h32, 1, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].dv, vecs[i].din, vecs[i].last, vecs[i].sel,
            vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_v0, vecs[i].e_d0,
               vecs[i].e_l0, vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_l1, vecs[i].e_busy);
      tick();
    end

    // Reset while a packet to output 1 is open and its head beat is stalled.
    drive(1'b0, 1'b1, 8'h61, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_outs("rstlock.pre", 1'b0, 1'b0, 8'h52, 1'b1, 1'b1, 8'h61, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h71, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_outs("rstlock.post", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_outs("rstlock.route", 1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();

    // Randomized traffic against the model, starting from a clean reset.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    model_clear();
    for (int i = 0; i < N_RANDOM; i++) begin
      drive(($urandom_range(0, 255) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      model_cycle(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_stream_demux_2way
`default_nettype wire
